// File: rtl/sodor_instr_stim_gen.sv
// Seeded random RISC-V instruction source for the sodor5 imem response port: warm-up NOPs,
// NUM_INSTR random R/I/load words, then drain NOPs. Optional macro: SODOR_HAZARD_AVOID_EN.
module sodor_instr_stim_gen #(
    parameter logic [31:0] SEED        = 32'h000000B4,
    parameter int          MODE        = 0,
    parameter int          NUM_INSTR   = 64,
    parameter int          WARMUP_NOPS = 4,
    parameter int          DRAIN_NOPS  = 5,
    parameter logic [11:0] LD_IMM_MASK = 12'h03C,
    parameter int          HAZ_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic        instr_is_nop,
    output logic [31:0] issued_count,
    output logic        done
);

    // state  | meaning
    // IDLE   | waiting for en, outputs NOP with valid low
    // WARMUP | issuing WARMUP_NOPS NOPs
    // RUN    | issuing NUM_INSTR random words, LFSR advances per accepted word
    // DRAIN  | issuing DRAIN_NOPS NOPs to flush the pipe
    // DONE   | terminal until reset
    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [31:0] NOP      = 32'h00000013;
    localparam logic [31:0] TAPS     = 32'h80200003;
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0] N_WARM   = 32'(WARMUP_NOPS);
    localparam logic [31:0] N_RUN    = 32'(NUM_INSTR);
    localparam logic [31:0] N_DRAIN  = 32'(DRAIN_NOPS);

    localparam logic [1:0] K_R  = 2'd0;
    localparam logic [1:0] K_I  = 2'd1;
    localparam logic [1:0] K_LD = 2'd2;

    state_t      state, state_d;
    logic [31:0] cnt, cnt_d;
    logic [31:0] lfsr, lfsr_d;
    logic [31:0] instr_d;
    logic        is_nop_d;
    logic        active;
    logic        accept;
    logic        run_accept;

    assign active       = (state == S_WARMUP) || (state == S_RUN) || (state == S_DRAIN);
    assign instr_valid  = active && en;
    assign accept       = instr_valid && instr_ready;
    assign run_accept   = accept && (state == S_RUN);
    assign done         = (state == S_DONE);

    // Each down-counter reloads on entry; a zero count falls through to the following phase.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        lfsr_d  = lfsr;
        case (state)
            S_IDLE: begin
                if (en) begin
                    if (N_WARM != 32'd0) begin
                        state_d = S_WARMUP;
                        cnt_d   = N_WARM;
                    end else if (N_RUN != 32'd0) begin
                        state_d = S_RUN;
                        cnt_d   = N_RUN;
                    end else if (N_DRAIN != 32'd0) begin
                        state_d = S_DRAIN;
                        cnt_d   = N_DRAIN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WARMUP: begin
                if (accept) begin
                    if (cnt == 32'd1) begin
                        if (N_RUN != 32'd0) begin
                            state_d = S_RUN;
                            cnt_d   = N_RUN;
                        end else if (N_DRAIN != 32'd0) begin
                            state_d = S_DRAIN;
                            cnt_d   = N_DRAIN;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        cnt_d = cnt - 32'd1;
                    end
                end
            end
            S_RUN: begin
                if (accept) begin
                    lfsr_d = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'd0);
                    if (cnt == 32'd1) begin
                        if (N_DRAIN != 32'd0) begin
                            state_d = S_DRAIN;
                            cnt_d   = N_DRAIN;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        cnt_d = cnt - 32'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (accept) begin
                    if (cnt == 32'd1) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt - 32'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    logic [4:0]  rd_f, rs1_raw, rs2_raw, rs1_f, rs2_f;
    logic [2:0]  f3_f;
    logic [11:0] imm_f, imm_i;
    logic [1:0]  sel_f, kind;
    logic        alt_f;
    logic [6:0]  f7_f;
    logic [31:0] enc;

    assign rd_f    = lfsr_d[4:0];
    assign rs1_raw = lfsr_d[9:5];
    assign rs2_raw = lfsr_d[14:10];
    assign f3_f    = lfsr_d[17:15];
    assign imm_f   = lfsr_d[29:18];
    assign sel_f   = lfsr_d[31:30];
    assign alt_f   = lfsr_d[31] ^ lfsr_d[0];

`ifdef SODOR_HAZARD_AVOID_EN
    logic [4:0] hist   [HAZ_DEPTH];
    logic [4:0] hist_d [HAZ_DEPTH];

    always_comb begin
        hist_d = hist;
        if (run_accept) begin
            hist_d[0] = lfsr[4:0];
            for (int i = 1; i < HAZ_DEPTH; i++) begin
                hist_d[i] = hist[i-1];
            end
        end
    end

    // Source registers that match a recent non-zero destination are redirected to x0.
    always_comb begin
        rs1_f = rs1_raw;
        rs2_f = rs2_raw;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (hist_d[i] != 5'd0 && rs1_raw == hist_d[i]) rs1_f = 5'd0;
            if (hist_d[i] != 5'd0 && rs2_raw == hist_d[i]) rs2_f = 5'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < HAZ_DEPTH; i++) hist[i] <= 5'd0;
        end else begin
            hist <= hist_d;
        end
    end
`else
    assign rs1_f = rs1_raw;
    assign rs2_f = rs2_raw;
`endif

    always_comb begin
        kind = K_R;
        case (MODE)
            1:       kind = K_I;
            2:       kind = sel_f[0] ? K_I : K_R;
            3:       kind = (sel_f == 2'd3) ? K_LD : ((sel_f == 2'd2) ? K_I : K_R);
            default: kind = K_R;
        endcase
    end

    always_comb begin
        f7_f  = (alt_f && (f3_f == 3'd0 || f3_f == 3'd5)) ? 7'b0100000 : 7'b0000000;
        imm_i = imm_f;
        if (f3_f == 3'd1) imm_i = imm_f & 12'h01F;
        else if (f3_f == 3'd5) imm_i = imm_f & 12'h41F;
        case (kind)
            K_I:     enc = {imm_i, rs1_f, f3_f, rd_f, 7'b0010011};
            K_LD:    enc = {imm_f & LD_IMM_MASK, 5'd0, f3_f & 3'b100, rd_f, 7'b0000011};
            default: enc = {f7_f, rs2_f, rs1_f, f3_f, rd_f, 7'b0110011};
        endcase
    end

    // The output word is precomputed for the state/LFSR of the next cycle, so it is
    // registered yet ready the cycle after an accept.
    always_comb begin
        instr_d  = (state_d == S_RUN) ? enc : NOP;
        is_nop_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= 32'd0;
            lfsr         <= SEED_EFF;
            instr        <= NOP;
            instr_is_nop <= 1'b1;
            issued_count <= 32'd0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            lfsr         <= lfsr_d;
            instr        <= instr_d;
            instr_is_nop <= is_nop_d;
            if (run_accept && issued_count != 32'hFFFFFFFF) begin
                issued_count <= issued_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_sodor_instr_stim_gen.sv
// Bench for sodor_instr_stim_gen: two instances (MODE 0 short run, MODE 3 long run)
// checked against a word-level reference model with random ready/en.
module tb_sodor_instr_stim_gen;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return (l >> 1) ^ ((l & 32'd1) != 0 ? 32'h80200003 : 32'd0);
    endfunction

    // Reference word built arithmetically from the field rules.
    function automatic logic [31:0] model_word(input logic [31:0] l, input int mode,
                                               input int h0, input int h1);
        int unsigned rd, rs1, rs2, f3, imm, sel, alt, f7, kind;
        rd  = l % 32;
        rs1 = (l / 32) % 32;
        rs2 = (l >> 10) % 32;
        f3  = (l >> 15) % 8;
        imm = (l >> 18) % 4096;
        sel = l >> 30;
        alt = ((l >> 31) ^ l) & 1;
`ifdef SODOR_HAZARD_AVOID_EN
        if ((h0 != 0 && rs1 == h0) || (h1 != 0 && rs1 == h1)) rs1 = 0;
        if ((h0 != 0 && rs2 == h0) || (h1 != 0 && rs2 == h1)) rs2 = 0;
`else
        if (h0 < 0 || h1 < 0) rs1 = 0;
`endif
        if (mode == 0) kind = 0;
        else if (mode == 1) kind = 1;
        else if (mode == 2) kind = sel % 2;
        else kind = (sel < 2) ? 0 : ((sel == 2) ? 1 : 2);
        if (kind == 0) begin
            f7 = (alt == 1 && (f3 == 0 || f3 == 5)) ? 32 : 0;
            return 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 51);
        end else if (kind == 1) begin
            if (f3 == 1) imm = imm & 32'h01F;
            else if (f3 == 5) imm = imm & 32'h41F;
            return 32'((imm << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 19);
        end
        return 32'(((imm & 32'h03C) << 20) | ((f3 & 4) << 12) | (rd << 7) | 3);
    endfunction

    // ---------------- instance A: MODE 0, 3 warm-up, 12 random, 5 drain ----------------
    logic        rst_a, en_a, rdy_a, val_a, nop_a, done_a;
    logic [31:0] ins_a, cnt_a;

    sodor_instr_stim_gen #(
        .SEED(32'h000000B4), .MODE(0), .NUM_INSTR(12), .WARMUP_NOPS(3),
        .DRAIN_NOPS(5), .LD_IMM_MASK(12'h03C), .HAZ_DEPTH(2)
    ) dut_a (
        .clk(clk), .reset(rst_a), .en(en_a), .instr_ready(rdy_a),
        .instr_valid(val_a), .instr(ins_a), .instr_is_nop(nop_a),
        .issued_count(cnt_a), .done(done_a)
    );

    // ---------------- instance B: MODE 3, no warm-up/drain, 1000 random ----------------
    logic        rst_b, en_b, rdy_b, val_b, nop_b, done_b;
    logic [31:0] ins_b, cnt_b;

    sodor_instr_stim_gen #(
        .SEED(32'h000000B4), .MODE(3), .NUM_INSTR(1000), .WARMUP_NOPS(0),
        .DRAIN_NOPS(0), .LD_IMM_MASK(12'h03C), .HAZ_DEPTH(2)
    ) dut_b (
        .clk(clk), .reset(rst_b), .en(en_b), .instr_ready(rdy_b),
        .instr_valid(val_b), .instr(ins_b), .instr_is_nop(nop_b),
        .issued_count(cnt_b), .done(done_b)
    );

    logic [31:0] exp_a [20];
    logic [31:0] exp_nop_a [20];
    logic [31:0] cap_a [$];
    logic [31:0] cap_first [$];
    int          acc_a;

    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b1; en_a = 1'b0; rdy_a = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_instr", ins_a, NOP);
        chk("rst_valid", 32'(val_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_issued", cnt_a, 32'd0);
        chk("rst_isnop", 32'(nop_a), 32'd1);
        rst_a = 1'b0;
    endtask

    task automatic run_a(input int max_acc, input bit rnd, input bit stall_mid);
        int          exp_issued;
        int          stall_left;
        bit          prev_stall;
        logic [31:0] prev_word;
        int          cyc;
        exp_issued = 0; stall_left = 4; prev_stall = 0; prev_word = NOP;
        acc_a = 0;
        cap_a.delete();
        for (cyc = 0; cyc < 2000 && acc_a < max_acc && !done_a; cyc++) begin
            @(negedge clk);
            en_a  = rnd ? ($urandom_range(0, 9) != 0) : 1'b1;
            rdy_a = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (stall_mid && acc_a >= 8 && stall_left > 0) begin
                en_a = 1'b1; rdy_a = 1'b0; stall_left--;
            end
            #1;
            if (val_a && prev_stall) chk("hold", ins_a, prev_word);
            chk("issued_live", cnt_a, 32'(exp_issued));
            if (val_a && rdy_a) begin
                chk("word", ins_a, exp_a[acc_a]);
                chk("isnop", 32'(nop_a), exp_nop_a[acc_a]);
                cap_a.push_back(ins_a);
                if (exp_nop_a[acc_a] == 0) exp_issued++;
                acc_a++;
            end
            if (val_a) begin
                prev_stall = !rdy_a;
                prev_word  = ins_a;
            end
        end
        if (cyc >= 2000) chk("budget_a", 32'(acc_a), 32'(max_acc));
    endtask

    initial begin
        logic [31:0] l;
        int          h0, h1, nacc, cyc, stalls_seen;
        logic [31:0] w, e;

        rst_a = 1'b1; en_a = 1'b0; rdy_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0; rdy_b = 1'b0;

        l = 32'h000000B4;
        for (int i = 0; i < 20; i++) begin
            if (i < 3 || i >= 15) begin
                exp_a[i] = NOP; exp_nop_a[i] = 1;
            end else begin
                exp_a[i] = model_word(l, 0, 0, 0);
                exp_nop_a[i] = 0;
                l = lfsr_step(l);
            end
        end
`ifdef SODOR_HAZARD_AVOID_EN
        l = 32'h000000B4; h0 = 0; h1 = 0;
        for (int i = 3; i < 15; i++) begin
            exp_a[i] = model_word(l, 0, h0, h1);
            h1 = h0; h0 = int'(l % 32);
            l = lfsr_step(l);
        end
`endif

        // Full random run of A with a forced 4-cycle stall in RUN.
        reset_a();
        run_a(20, 1'b1, 1'b1);
        chk("accepted_a", 32'(acc_a), 32'd20);
        if (cap_a.size() > 3) chk("first_run", cap_a[3], 32'h00028A33);
        @(negedge clk);
        en_a = 1'b1; rdy_a = 1'b1;
        #1;
        chk("done", 32'(done_a), 32'd1);
        chk("done_valid", 32'(val_a), 32'd0);
        chk("done_issued", cnt_a, 32'd12);
        chk("done_instr", ins_a, NOP);
        repeat (3) @(negedge clk);
        #1;
        chk("done_sticky", 32'(done_a), 32'd1);

        // Deterministic run to 10 RUN words, reset mid-RUN, then a random rerun.
        reset_a();
        run_a(13, 1'b0, 1'b0);
        cap_first = cap_a;
        reset_a();
        run_a(13, 1'b1, 1'b0);
        chk("rerun_len", 32'(cap_a.size()), 32'd13);
        for (int i = 3; i < 13 && i < cap_a.size() && i < cap_first.size(); i++)
            chk("rerun_word", cap_a[i], cap_first[i]);

        // Instance B: MODE 3, zero warm-up/drain, random handshake.
        rst_a = 1'b1;
        @(negedge clk);
        #1;
        chk("b_rst_instr", ins_b, NOP);
        chk("b_rst_issued", cnt_b, 32'd0);
        rst_b = 1'b0;
        l = 32'h000000B4; h0 = 0; h1 = 0; nacc = 0; stalls_seen = 0;
        for (cyc = 0; cyc < 6000 && !done_b; cyc++) begin
            @(negedge clk);
            en_b  = ($urandom_range(0, 9) != 0);
            rdy_b = ($urandom_range(0, 3) != 0);
            #1;
            if (val_b && !rdy_b) stalls_seen++;
            if (val_b && rdy_b) begin
                w = ins_b;
                e = model_word(l, 3, h0, h1);
                chk("b_word", w, e);
                chk("b_isnop", 32'(nop_b), 32'd0);
                if (w[6:0] == 7'h03) begin
                    chk("ld_rs1", 32'(w[19:15]), 32'd0);
                    chk("ld_imm", 32'(w[31:20] & ~12'h03C), 32'd0);
                end
                if (w[6:0] == 7'h13 && w[14:12] == 3'd1) chk("slli_imm", 32'(w[31:25]), 32'd0);
                if (w[6:0] == 7'h13 && w[14:12] == 3'd5)
                    chk("srai_imm", 32'(w[31:25] == 7'd0 || w[31:25] == 7'd32), 32'd1);
`ifdef SODOR_HAZARD_AVOID_EN
                if (w[6:0] != 7'h03) begin
                    chk("haz_rs1", 32'((h0 != 0 && w[19:15] == h0) || (h1 != 0 && w[19:15] == h1)), 32'd0);
                end
                if (w[6:0] == 7'h33) begin
                    chk("haz_rs2", 32'((h0 != 0 && w[24:20] == h0) || (h1 != 0 && w[24:20] == h1)), 32'd0);
                end
`endif
                h1 = h0; h0 = int'(l % 32);
                l = lfsr_step(l);
                nacc++;
            end
        end
        if (cyc >= 6000) chk("budget_b", 32'(nacc), 32'd1000);
        @(negedge clk);
        #1;
        chk("b_accepted", 32'(nacc), 32'd1000);
        chk("b_issued", cnt_b, 32'd1000);
        chk("b_done", 32'(done_b), 32'd1);
        chk("b_valid_done", 32'(val_b), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
